// File: rtl/id_ex_stage.sv
// id_ex_stage
// ID/EX pipeline register for the 16-bit pipelined MIPS datapath, with
// EX/MEM and MEM/WB operand forwarding and load-use hazard detection.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   id_*                      decoded operands/control from ID (captured each edge)
//   stall, flush              hold all state / load a bubble (flush wins)
//   exmem_*, memwb_*          forwarding sources (write enable, dest, result)
//   ex_ina, ex_inb            ALU operands (forwarded rs; imm or forwarded rt)
//   ex_alu_control            registered ALU control code
//   ex_store_data             forwarded rt, used as store data
//   ex_write_reg              destination register chosen at capture time
//   ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg
//                             registered control
//   load_use_hazard           combinational request to the hazard unit
module id_ex_stage #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic [AW-1:0] id_rd,
  input  logic [2:0]    id_alu_op,
  input  logic          id_alu_src,
  input  logic          id_reg_dst,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_mem_to_reg,
  input  logic          stall,
  input  logic          flush,
  input  logic          exmem_reg_write,
  input  logic [AW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_reg_write,
  input  logic [AW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic [DW-1:0] ex_ina,
  output logic [DW-1:0] ex_inb,
  output logic [2:0]    ex_alu_control,
  output logic [DW-1:0] ex_store_data,
  output logic [AW-1:0] ex_write_reg,
  output logic          ex_valid,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_mem_to_reg,
  output logic          load_use_hazard
);

  logic [DW-1:0] rs_data_reg, rt_data_reg, imm_reg;
  logic [AW-1:0] rs_reg, rt_reg, write_reg_reg;
  logic [2:0]    alu_op_reg;
  logic          valid_reg, alu_src_reg, reg_write_reg;
  logic          mem_read_reg, mem_write_reg, mem_to_reg_reg;

  // A bubble is all zeros: with index 0 it can never match a forwarding
  // source, and with valid/control cleared it has no side effects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      rs_data_reg    <= '0;
      rt_data_reg    <= '0;
      imm_reg        <= '0;
      rs_reg         <= '0;
      rt_reg         <= '0;
      write_reg_reg  <= '0;
      alu_op_reg     <= '0;
      valid_reg      <= 1'b0;
      alu_src_reg    <= 1'b0;
      reg_write_reg  <= 1'b0;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      mem_to_reg_reg <= 1'b0;
    end else if (!stall) begin
      rs_data_reg    <= id_rs_data;
      rt_data_reg    <= id_rt_data;
      imm_reg        <= id_imm;
      rs_reg         <= id_rs;
      rt_reg         <= id_rt;
      write_reg_reg  <= id_reg_dst ? id_rd : id_rt;
      alu_op_reg     <= id_alu_op;
      valid_reg      <= id_valid;
      alu_src_reg    <= id_alu_src;
      reg_write_reg  <= id_reg_write;
      mem_read_reg   <= id_mem_read;
      mem_write_reg  <= id_mem_write;
      mem_to_reg_reg <= id_mem_to_reg;
    end
  end

  // Register 0 is hard-wired to zero, so a write to it is never forwarded.
  logic exmem_hit_rs, exmem_hit_rt, memwb_hit_rs, memwb_hit_rt;
  assign exmem_hit_rs = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs_reg);
  assign exmem_hit_rt = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rt_reg);
  assign memwb_hit_rs = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs_reg);
  assign memwb_hit_rt = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rt_reg);

  logic [DW-1:0] fwd_rs, fwd_rt;

  // The most recent producer (EX/MEM) takes priority over MEM/WB.
  always_comb begin
    fwd_rs = rs_data_reg;
    if (exmem_hit_rs)      fwd_rs = exmem_result;
    else if (memwb_hit_rs) fwd_rs = memwb_result;
  end

  always_comb begin
    fwd_rt = rt_data_reg;
    if (exmem_hit_rt)      fwd_rt = exmem_result;
    else if (memwb_hit_rt) fwd_rt = memwb_result;
  end

  assign ex_ina         = fwd_rs;
  assign ex_store_data  = fwd_rt;
  assign ex_inb         = alu_src_reg ? imm_reg : fwd_rt;
  assign ex_alu_control = alu_op_reg;
  assign ex_write_reg   = write_reg_reg;
  assign ex_valid       = valid_reg;
  assign ex_reg_write   = reg_write_reg;
  assign ex_mem_read    = mem_read_reg;
  assign ex_mem_write   = mem_write_reg;
  assign ex_mem_to_reg  = mem_to_reg_reg;

  // A load in EX cannot supply its data to the instruction now in ID in time;
  // the hazard unit stalls IF/ID and flushes this stage in response.
  assign load_use_hazard = valid_reg && mem_read_reg && (write_reg_reg != '0) &&
                           ((write_reg_reg == id_rs) || (write_reg_reg == id_rt));

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  localparam int DW = 16;
  localparam int AW = 3;

  localparam int S_INA = 0, S_INB = 1, S_ALU = 2, S_STORE = 3, S_WREG = 4,
                 S_VALID = 5, S_RW = 6, S_MR = 7, S_MW = 8, S_M2R = 9, S_LUH = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          id_valid = 1'b0;
  logic [DW-1:0] id_rs_data = '0, id_rt_data = '0, id_imm = '0;
  logic [AW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic [2:0]    id_alu_op = '0;
  logic          id_alu_src = 1'b0, id_reg_dst = 1'b0, id_reg_write = 1'b0;
  logic          id_mem_read = 1'b0, id_mem_write = 1'b0, id_mem_to_reg = 1'b0;
  logic          stall = 1'b0, flush = 1'b0;
  logic          exmem_reg_write = 1'b0, memwb_reg_write = 1'b0;
  logic [AW-1:0] exmem_rd = '0, memwb_rd = '0;
  logic [DW-1:0] exmem_result = '0, memwb_result = '0;
  logic [DW-1:0] ex_ina, ex_inb, ex_store_data;
  logic [2:0]    ex_alu_control;
  logic [AW-1:0] ex_write_reg;
  logic          ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic          load_use_hazard;

  id_ex_stage #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_op(id_alu_op),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .stall(stall), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .ex_ina(ex_ina), .ex_inb(ex_inb), .ex_alu_control(ex_alu_control),
    .ex_store_data(ex_store_data), .ex_write_reg(ex_write_reg), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .load_use_hazard(load_use_hazard)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    int            sel;
    logic [DW-1:0] exp;
  } exp_t;

  exp_t scoreboard[$];
  int   errors = 0;
  int   checks = 0;
  bit   stim_done = 1'b0;

  function automatic logic [DW-1:0] observe(input int sel);
    case (sel)
      S_INA:   return ex_ina;
      S_INB:   return ex_inb;
      S_ALU:   return DW'(ex_alu_control);
      S_STORE: return ex_store_data;
      S_WREG:  return DW'(ex_write_reg);
      S_VALID: return DW'(ex_valid);
      S_RW:    return DW'(ex_reg_write);
      S_MR:    return DW'(ex_mem_read);
      S_MW:    return DW'(ex_mem_write);
      S_M2R:   return DW'(ex_mem_to_reg);
      default: return DW'(load_use_hazard);
    endcase
  endfunction

  task automatic expect_out(input string name, input int sel, input logic [DW-1:0] v);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = v;
    scoreboard.push_back(e);
  endtask

  // Monitor: the DUT outputs are sampled on the falling edge, away from the
  // capture edge; every queued expectation is retired there.
  initial begin
    forever begin
      @(negedge clk);
      while (scoreboard.size() > 0) begin
        exp_t e;
        logic [DW-1:0] act;
        e = scoreboard.pop_front();
        act = observe(e.sel);
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end else begin
          $display("ok   %s: %h", e.name, act);
        end
      end
    end
  end

  task automatic cap();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    // Reset state at power-on.
    cap();
    expect_out("rst_ina", S_INA, 16'h0);
    expect_out("rst_inb", S_INB, 16'h0);
    expect_out("rst_alu", S_ALU, 16'h0);
    expect_out("rst_store", S_STORE, 16'h0);
    expect_out("rst_wreg", S_WREG, 16'h0);
    expect_out("rst_valid", S_VALID, 16'h0);
    expect_out("rst_rw", S_RW, 16'h0);
    expect_out("rst_mr", S_MR, 16'h0);
    expect_out("rst_mw", S_MW, 16'h0);
    expect_out("rst_m2r", S_M2R, 16'h0);
    expect_out("rst_luh", S_LUH, 16'h0);
    settle();
    rst = 1'b0;

    // Load real data, then reset asynchronously before any further edge.
    id_valid = 1'b1; id_rs_data = 16'h5555; id_alu_op = 3'b111;
    id_reg_write = 1'b1; id_mem_write = 1'b1; id_mem_to_reg = 1'b1;
    cap();
    rst = 1'b1;
    expect_out("async_rst_ina", S_INA, 16'h0);
    expect_out("async_rst_alu", S_ALU, 16'h0);
    expect_out("async_rst_valid", S_VALID, 16'h0);
    expect_out("async_rst_rw", S_RW, 16'h0);
    expect_out("async_rst_mw", S_MW, 16'h0);
    settle();
    rst = 1'b0;

    // First capture after release.
    id_rs_data = 16'h1234; id_alu_op = 3'b010; id_reg_write = 1'b0;
    cap();
    expect_out("cap_ina", S_INA, 16'h1234);
    expect_out("cap_alu", S_ALU, 16'h0002);
    expect_out("cap_valid", S_VALID, 16'h1);
    expect_out("cap_rw", S_RW, 16'h0);
    expect_out("cap_mw", S_MW, 16'h1);
    expect_out("cap_m2r", S_M2R, 16'h1);
    settle();

    // EX/MEM forwarding on rs, then a write to r0 is not forwarded.
    id_rs = 3'd3; id_rs_data = 16'h1111; id_mem_write = 1'b0; id_mem_to_reg = 1'b0;
    cap();
    exmem_reg_write = 1'b1; exmem_rd = 3'd3; exmem_result = 16'h00AA;
    expect_out("exmem_fwd_rs", S_INA, 16'h00AA);
    settle();
    exmem_rd = 3'd0;
    expect_out("exmem_r0_nofwd", S_INA, 16'h1111);
    settle();

    // Priority: EX/MEM over MEM/WB on rt.
    id_rt = 3'd5; id_rt_data = 16'h2222; id_alu_src = 1'b0;
    cap();
    exmem_reg_write = 1'b1; exmem_rd = 3'd5; exmem_result = 16'hBEEF;
    memwb_reg_write = 1'b1; memwb_rd = 3'd5; memwb_result = 16'hCAFE;
    expect_out("prio_inb", S_INB, 16'hBEEF);
    expect_out("prio_store", S_STORE, 16'hBEEF);
    expect_out("prio_ina_unaffected", S_INA, 16'h1111);
    settle();
    exmem_reg_write = 1'b0;
    expect_out("memwb_fwd_inb", S_INB, 16'hCAFE);
    settle();
    memwb_rd = 3'd0;
    expect_out("memwb_r0_nofwd", S_INB, 16'h2222);
    settle();

    // Immediate select while rt is forwarded.
    id_alu_src = 1'b1; id_imm = 16'hFFF0;
    cap();
    memwb_reg_write = 1'b1; memwb_rd = 3'd5; memwb_result = 16'h0042;
    expect_out("imm_inb", S_INB, 16'hFFF0);
    expect_out("imm_store", S_STORE, 16'h0042);
    settle();
    memwb_reg_write = 1'b0; memwb_rd = 3'd0;

    // Destination select: reg_dst=1 picks rd.
    id_reg_dst = 1'b1; id_rd = 3'd6; id_alu_src = 1'b0;
    cap();
    expect_out("regdst_rd", S_WREG, 16'd6);
    settle();

    // Load-use hazard.
    id_reg_dst = 1'b0; id_rt = 3'd2; id_rs = 3'd4; id_mem_read = 1'b1;
    id_reg_write = 1'b1; id_valid = 1'b1;
    cap();
    id_mem_read = 1'b0;
    expect_out("lu_wreg", S_WREG, 16'd2);
    expect_out("lu_mr", S_MR, 16'h1);
    expect_out("lu_hazard_rt", S_LUH, 16'h1);
    settle();
    id_rt = 3'd6; id_rs = 3'd7;
    stall = 1'b1;
    expect_out("lu_nomatch", S_LUH, 16'h0);
    settle();
    id_rs = 3'd2;
    expect_out("lu_hazard_rs", S_LUH, 16'h1);
    settle();
    id_rt = 3'd2; stall = 1'b1; flush = 1'b1;
    cap();
    stall = 1'b0; flush = 1'b0;
    expect_out("flush_valid", S_VALID, 16'h0);
    expect_out("flush_rw", S_RW, 16'h0);
    expect_out("flush_mr", S_MR, 16'h0);
    expect_out("flush_wreg", S_WREG, 16'h0);
    expect_out("flush_luh", S_LUH, 16'h0);
    settle();

    // Stall hold for three edges while ID inputs change.
    id_rs = 3'd1; id_rs_data = 16'h0007; id_alu_op = 3'b001; id_mem_read = 1'b0;
    cap();
    stall = 1'b1;
    id_alu_op = 3'b110; id_rs_data = 16'h9999; id_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cap();
      expect_out($sformatf("stall%0d_alu", i), S_ALU, 16'h0001);
      expect_out($sformatf("stall%0d_ina", i), S_INA, 16'h0007);
      expect_out($sformatf("stall%0d_valid", i), S_VALID, 16'h1);
      settle();
    end
    exmem_reg_write = 1'b1; exmem_rd = 3'd1; exmem_result = 16'h0ABC;
    expect_out("stall_fwd_ina", S_INA, 16'h0ABC);
    settle();
    exmem_reg_write = 1'b0;
    stall = 1'b0;
    cap();
    expect_out("unstall_alu", S_ALU, 16'h0006);
    expect_out("unstall_ina", S_INA, 16'h9999);
    expect_out("unstall_valid", S_VALID, 16'h0);
    settle();
    stim_done = 1'b1;
  end

  // Finish once the scoreboard drains, bounded by a cycle budget.
  initial begin
    int budget;
    budget = 0;
    wait (stim_done);
    while (scoreboard.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    if (scoreboard.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d pending expectations left, required 0", scoreboard.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: stimulus did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
